// File: rtl/fsm_bubblesort_mb.sv
// Multi-bank bubble sorter: load, sort and unload run concurrently on different banks.
// Sort latency is n(n-1)/2+3 cycles; in_rdy drops when the enqueue bank is busy, and output holds under !out_rdy.
module fsm_bubblesort_mb #(
  parameter int N      = 16,
  parameter int W      = 32,
  parameter int BANK_N = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  input  logic [W-1:0]      in_dat,
  input  logic              in_last,
  input  logic              in_desc,
  input  logic              in_signed,
  output logic              in_rdy,
  output logic              out_vld,
  output logic [W-1:0]      out_dat,
  output logic              out_last,
  output logic              out_err,
  input  logic              out_rdy,
  output logic [BANK_N-1:0] bank_busy
);

  localparam int CW = $clog2(N) + 1;
  localparam int KW = $clog2(N);
  localparam int PW = (BANK_N > 1) ? $clog2(BANK_N) : 1;

  typedef enum logic [2:0] {
    B_IDLE, B_LOADING, B_READY, B_SORTING, B_SORTED, B_UNLOADING
  } bank_st_t;

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_PASS, S_DONE
  } srt_st_t;

  bank_st_t      bst    [BANK_N];
  logic [CW-1:0] cnt    [BANK_N];
  logic          desc_q [BANK_N];
  logic          sgn_q  [BANK_N];
  logic          err_q  [BANK_N];
  logic [W-1:0]  mem    [BANK_N][N];

  logic [PW-1:0] enq_ptr, srt_ptr, deq_ptr;
  logic [CW-1:0] ld_idx, rd_idx, lim;
  logic [KW-1:0] k, k1;
  logic          swapped, run;
  srt_st_t       srt_st, srt_nx;

  logic          accept, last_beat;
  logic [W-1:0]  cmp_a, cmp_b;
  logic          a_gt_b, a_lt_b, do_swap, pass_end, finish;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BANK_N - 1)) ? '0 : p + PW'(1);
  endfunction

  // run keeps in_rdy low while reset is held even though every bank reads IDLE
  assign in_rdy    = run && (bst[enq_ptr] == B_IDLE || bst[enq_ptr] == B_LOADING);
  assign accept    = in_vld && in_rdy;
  assign last_beat = in_last || (ld_idx == CW'(N - 1));

  always_comb begin
    k1       = k + KW'(1);
    cmp_a    = mem[srt_ptr][k];
    cmp_b    = mem[srt_ptr][k1];
    a_gt_b   = 1'b0;
    a_lt_b   = 1'b0;
    if (sgn_q[srt_ptr]) begin
      a_gt_b = $signed(cmp_a) > $signed(cmp_b);
      a_lt_b = $signed(cmp_a) < $signed(cmp_b);
    end else begin
      a_gt_b = cmp_a > cmp_b;
      a_lt_b = cmp_a < cmp_b;
    end
    do_swap  = (srt_st == S_PASS) && (desc_q[srt_ptr] ? a_lt_b : a_gt_b);
    pass_end = ({1'b0, k} == lim - CW'(2));
    finish   = pass_end && (!(swapped || do_swap) || lim == CW'(2));
  end

  always_comb begin
    bank_busy = '0;
    for (int i = 0; i < BANK_N; i++) begin
      bank_busy[i] = (bst[i] != B_IDLE);
    end
  end

  always_comb begin
    srt_nx = srt_st;
    case (srt_st)
      S_IDLE:  if (bst[srt_ptr] == B_READY) srt_nx = S_START;
      S_START: srt_nx = (cnt[srt_ptr] < CW'(2)) ? S_DONE : S_PASS;
      S_PASS:  if (finish) srt_nx = S_DONE;
      S_DONE:  srt_nx = S_IDLE;
      default: srt_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) srt_st <= S_IDLE;
    else        srt_st <= srt_nx;
  end

  // Storage is not reset; every write is qualified by reset-cleared control state.
  always_ff @(posedge clk) begin
    if (accept) mem[enq_ptr][ld_idx[KW-1:0]] <= in_dat;
    if (do_swap) begin
      mem[srt_ptr][k]  <= cmp_b;
      mem[srt_ptr][k1] <= cmp_a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BANK_N; i++) begin
        bst[i]    <= B_IDLE;
        cnt[i]    <= '0;
        desc_q[i] <= 1'b0;
        sgn_q[i]  <= 1'b0;
        err_q[i]  <= 1'b0;
      end
      enq_ptr  <= '0;
      srt_ptr  <= '0;
      deq_ptr  <= '0;
      ld_idx   <= '0;
      rd_idx   <= '0;
      lim      <= '0;
      k        <= '0;
      swapped  <= 1'b0;
      run      <= 1'b0;
      out_vld  <= 1'b0;
      out_dat  <= '0;
      out_last <= 1'b0;
      out_err  <= 1'b0;
    end else begin
      run <= 1'b1;

      if (accept) begin
        if (bst[enq_ptr] == B_IDLE) begin
          desc_q[enq_ptr] <= in_desc;
          sgn_q[enq_ptr]  <= in_signed;
          bst[enq_ptr]    <= B_LOADING;
        end
        if (last_beat) begin
          bst[enq_ptr] <= B_READY;
          cnt[enq_ptr] <= ld_idx + CW'(1);
          err_q[enq_ptr] <= !in_last;
          enq_ptr      <= ptr_inc(enq_ptr);
          ld_idx       <= '0;
        end else begin
          ld_idx <= ld_idx + CW'(1);
        end
      end

      case (srt_st)
        S_IDLE: if (srt_nx == S_START) bst[srt_ptr] <= B_SORTING;
        S_START: begin
          lim     <= cnt[srt_ptr];
          k       <= '0;
          swapped <= 1'b0;
        end
        S_PASS: begin
          if (pass_end) begin
            if (!finish) begin
              lim     <= lim - CW'(1);
              k       <= '0;
              swapped <= 1'b0;
            end
          end else begin
            k       <= k1;
            swapped <= swapped || do_swap;
          end
        end
        S_DONE: begin
          bst[srt_ptr] <= B_SORTED;
          srt_ptr      <= ptr_inc(srt_ptr);
        end
        default: ;
      endcase

      // First word is issued in the same cycle the bank leaves SORTED.
      if (out_vld && out_rdy && out_last) begin
        out_vld      <= 1'b0;
        out_dat      <= '0;
        out_last     <= 1'b0;
        out_err      <= 1'b0;
        bst[deq_ptr] <= B_IDLE;
        deq_ptr      <= ptr_inc(deq_ptr);
      end else if (!out_vld || out_rdy) begin
        if (bst[deq_ptr] == B_SORTED) begin
          bst[deq_ptr] <= B_UNLOADING;
          out_vld      <= 1'b1;
          out_dat      <= mem[deq_ptr][0];
          out_last     <= (cnt[deq_ptr] == CW'(1));
          out_err      <= err_q[deq_ptr];
          rd_idx       <= CW'(1);
        end else if (bst[deq_ptr] == B_UNLOADING && rd_idx < cnt[deq_ptr]) begin
          out_vld  <= 1'b1;
          out_dat  <= mem[deq_ptr][rd_idx[KW-1:0]];
          out_last <= (rd_idx == cnt[deq_ptr] - CW'(1));
          out_err  <= err_q[deq_ptr];
          rd_idx   <= rd_idx + CW'(1);
        end else begin
          out_vld <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fsm_bubblesort_mb.sv
// Randomised scoreboard bench for fsm_bubblesort_mb with a queue-sort reference model.
module tb_fsm_bubblesort_mb;
  localparam int N      = 16;
  localparam int W      = 32;
  localparam int BANK_N = 2;
  localparam logic [W-1:0] MSB = {1'b1, {(W-1){1'b0}}};

  typedef struct packed {
    logic [W-1:0] dat;
    logic         last;
    logic         err;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_vld = 1'b0;
  logic [W-1:0]      in_dat = '0;
  logic              in_last = 1'b0;
  logic              in_desc = 1'b0;
  logic              in_signed = 1'b0;
  logic              in_rdy;
  logic              out_vld;
  logic [W-1:0]      out_dat;
  logic              out_last;
  logic              out_err;
  logic              out_rdy = 1'b0;
  logic [BANK_N-1:0] bank_busy;

  fsm_bubblesort_mb #(.N(N), .W(W), .BANK_N(BANK_N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_dat(in_dat), .in_last(in_last),
    .in_desc(in_desc), .in_signed(in_signed), .in_rdy(in_rdy),
    .out_vld(out_vld), .out_dat(out_dat), .out_last(out_last),
    .out_err(out_err), .out_rdy(out_rdy), .bank_busy(bank_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 1;

  exp_t         sb[$];
  exp_t         mon_e;
  logic [W-1:0] cur[$];
  logic         cur_desc, cur_sgn;
  logic [W-1:0] job_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: sort by key (MSB flipped for signed), reverse for descending.
  task automatic close_job(input logic err);
    logic [W-1:0] keys[$];
    exp_t e;
    keys = {};
    foreach (cur[i]) keys.push_back(cur_sgn ? (cur[i] ^ MSB) : cur[i]);
    keys.sort();
    if (cur_desc) keys.reverse();
    foreach (keys[i]) begin
      e.dat  = cur_sgn ? (keys[i] ^ MSB) : keys[i];
      e.last = (i == keys.size() - 1);
      e.err  = err;
      sb.push_back(e);
    end
    cur.delete();
  endtask

  task automatic model_beat(input logic [W-1:0] d, input logic l, input logic ds, input logic sg);
    if (cur.size() == 0) begin
      cur_desc = ds;
      cur_sgn  = sg;
    end
    cur.push_back(d);
    if (l || cur.size() == N) close_job(!l);
  endtask

  // Called at a negedge; returns at the negedge after the beat transferred.
  task automatic send_beat(input logic [W-1:0] d, input logic l, input logic ds, input logic sg);
    int t;
    t = 0;
    in_vld = 1'b1; in_dat = d; in_last = l; in_desc = ds; in_signed = sg;
    while (!in_rdy && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!in_rdy) begin
      checks++;
      errors++;
      $display("FAIL in_rdy_timeout: got in_rdy=0 expected 1 within 3000 cycles");
    end else begin
      @(negedge clk);
      model_beat(d, l, ds, sg);
    end
    in_vld = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_job(input logic ds, input logic sg, input bit gaps);
    for (int i = 0; i < job_q.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      send_beat(job_q[i], (i == job_q.size() - 1), ds, sg);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    case ($urandom_range(0, 2))
      0:       return W'($urandom);
      1:       return W'($urandom_range(0, 5));
      default: return W'($urandom_range(0, 7)) - W'(4);
    endcase
  endfunction

  task automatic fill_job(input int len);
    job_q = {};
    for (int i = 0; i < len; i++) job_q.push_back(rand_word());
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || bank_busy != 0 || out_vld) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_sb_empty", 64'(sb.size()), 64'd0);
    chk("drain_bank_busy", 64'(bank_busy), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_out_dat", 64'(out_dat), 64'd0);
    chk("rst_out_last_err", 64'({out_last, out_err}), 64'd0);
    chk("rst_bank_busy", 64'(bank_busy), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd0);
    sb.delete();
    cur.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("in_rdy_after_release", 64'(in_rdy), 64'd1);
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_rdy = 1'b0;
      1:       out_rdy = 1'b1;
      default: out_rdy = ($urandom_range(0, 3) != 0);
    endcase
  end

  always @(negedge clk) begin
    if (rst_n && out_vld && out_rdy) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: got %0h expected no output", out_dat);
      end else begin
        mon_e = sb.pop_front();
        chk("out_word", {30'b0, out_err, out_last, out_dat}, {30'b0, mon_e.err, mon_e.last, mon_e.dat});
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("reset_in_rdy", 64'(in_rdy), 64'd0);
    chk("reset_out_vld", 64'(out_vld), 64'd0);
    chk("reset_out_dat", 64'(out_dat), 64'd0);
    chk("reset_out_last", 64'(out_last), 64'd0);
    chk("reset_out_err", 64'(out_err), 64'd0);
    chk("reset_bank_busy", 64'(bank_busy), 64'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("in_rdy_first_cycle", 64'(in_rdy), 64'd1);

    // ascending unsigned
    job_q = {32'd3, 32'd1, 32'd2, 32'd0};
    send_job(1'b0, 1'b0, 1'b0);
    wait_drain();

    // descending signed
    job_q = {32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd2};
    send_job(1'b1, 1'b1, 1'b0);
    wait_drain();

    // 17-word stream: truncated 16-word job plus a 1-word job
    fill_job(17);
    send_job(1'b0, 1'b1, 1'b0);
    wait_drain();

    // single-word latency
    job_q = {32'd7};
    send_job(1'b0, 1'b0, 1'b0);
    t = 0;
    while (!out_vld && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("single_word_latency_le5", 64'(t <= 5), 64'd1);
    wait_drain();

    // three jobs against a stalled output
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    fill_job(4);
    send_job(1'b0, 1'b0, 1'b0);
    fill_job(4);
    send_job(1'b1, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    chk("stall_in_rdy_low", 64'(in_rdy), 64'd0);
    chk("stall_bank_busy", 64'(bank_busy), 64'd3);
    chk("stall_out_vld", 64'(out_vld), 64'd1);
    chk("stall_out_dat_head", 64'(out_dat), 64'(sb[0].dat));
    rdy_mode = 1;
    t = 0;
    while (!in_rdy && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("in_rdy_returns", 64'(in_rdy), 64'd1);
    fill_job(3);
    send_job(1'b0, 1'b1, 1'b0);
    wait_drain();

    // randomised jobs with random backpressure and input gaps
    rdy_mode = 2;
    for (int j = 0; j < 25; j++) begin
      fill_job($urandom_range(1, N));
      send_job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    end
    wait_drain();

    // reset mid-sort
    rdy_mode = 1;
    fill_job(N);
    send_job(1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    do_reset();

    // reset mid-unload
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    fill_job(4);
    send_job(1'b1, 1'b1, 1'b0);
    t = 0;
    while (!out_vld && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("unload_started", 64'(out_vld), 64'd1);
    do_reset();

    // fresh job after reset
    rdy_mode = 1;
    fill_job(6);
    send_job(1'b0, 1'b1, 1'b0);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_bubblesort_mb.md
FSM_BUBBLESORT_MB -- requirements
Module: fsm_bubblesort_mb

Interface
REQ-001 SHALL have parameter N, default 16, maximum words per job (N >= 2).
REQ-002 SHALL have parameter W, default 32, data word width in bits.
REQ-003 SHALL have parameter BANK_N, default 2, number of job banks (BANK_N >= 1).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_vld  input  1  input word valid.
REQ-007 SHALL have port in_dat  input  W  input word.
REQ-008 SHALL have port in_last  input  1  final word of the job.
REQ-009 SHALL have port in_desc  input  1  job sort order: 0 ascending, 1 descending; sampled on the job's first beat.
REQ-010 SHALL have port in_signed  input  1  job compare mode: 0 unsigned, 1 two's complement; sampled on the job's first beat.
REQ-011 SHALL have port in_rdy  output  1  block accepts input word.
REQ-012 SHALL have port out_vld  output  1  output word valid.
REQ-013 SHALL have port out_dat  output  W  sorted output word.
REQ-014 SHALL have port out_last  output  1  final word of the job.
REQ-015 SHALL have port out_err  output  1  job was truncated at N words; valid with out_vld.
REQ-016 SHALL have port out_rdy  input  1  downstream accepts output word.
REQ-017 SHALL have port bank_busy  output  BANK_N  bank k not IDLE.

Function
REQ-018 Each bank SHALL hold N words, a count n (width clog2(N)+1), desc, signed, err and a status in {IDLE, LOADING, READY, SORTING, SORTED, UNLOADING}.
REQ-019 Input beat transfers when in_vld && in_rdy; in_rdy SHALL be 1 iff the enqueue-pointer bank is IDLE or LOADING.
REQ-020 Beats SHALL be written to consecutive addresses from 0; the first beat moves the bank IDLE->LOADING and captures in_desc/in_signed.
REQ-021 A beat with in_last, or the N-th beat, SHALL move the bank to READY and advance the enqueue pointer modulo BANK_N; the N-th beat without in_last sets err and later beats start the next job.
REQ-022 A single sort engine SHALL serve banks in enqueue order; sort FSM states IDLE, START, PASS, DONE.
REQ-023 IDLE->START when the sort-pointer bank is READY (bank -> SORTING); START sets limit L=n, k=0, swapped=0.
REQ-024 START->DONE if L<2; else ->PASS.
REQ-025 PASS SHALL compare words k and k+1 once per cycle, swapping them in the same cycle if out of order (ascending: a[k]>a[k+1]; descending: a[k]<a[k+1]); equal words never swap.
REQ-026 At k=L-2: if no swap during the pass or L=2 ->DONE; else L=L-1, k=0, swapped=0, stay in PASS.
REQ-027 DONE SHALL set bank SORTED, advance the sort pointer modulo BANK_N, ->IDLE.
REQ-028 Dequeue SHALL drain banks in enqueue order; the dequeue-pointer bank SORTED->UNLOADING, emitting words 0..n-1.
REQ-029 out_vld/out_dat/out_last/out_err SHALL be registered and held stable while out_vld && !out_rdy.
REQ-030 On the transfer with out_last the bank SHALL return to IDLE and the dequeue pointer advance.
REQ-031 Loading, sorting and unloading of different banks SHALL proceed concurrently without stall.
REQ-032 With BANK_N=1 the block SHALL serialise load, sort, unload on the one bank.
REQ-033 Sort SHALL complete within n(n-1)/2 + 3 cycles of entering SORTING.

Reset
REQ-034 While rst_n=0: all banks IDLE, all pointers 0, sort FSM IDLE, in_rdy=0, out_vld=0, out_dat=0, out_last=0, out_err=0, bank_busy=0.
REQ-035 First cycle after rst_n rises, in_rdy SHALL be 1.
REQ-036 Reset mid-operation SHALL discard all jobs; no partial output after release.

Verification
REQ-037 Ascending unsigned job {3,1,2,0} -> out 0,1,2,3, out_last on 3, out_err=0.
REQ-038 Descending signed job {-1,5,0x80000000,2} (W=32) -> out 5,2,-1,0x80000000.
REQ-039 N=16 unbroken stream of 17 words with no in_last -> job 1 is 16 words sorted, out_err=1; job 2 is the single 17th word, out_last=1.
REQ-040 Single-word job {7} -> one output 7, out_last=1, within 5 cycles of the input beat.
REQ-041 BANK_N=2, three back-to-back jobs with out_rdy=0 -> in_rdy falls after job 2; out_rdy=1 drains job 1 in order, then in_rdy returns to 1.
REQ-042 rst_n asserted mid-sort and mid-unload -> outputs zero immediately; a fresh job then sorts correctly.
